// File: rtl/reorder_retire_pkg.sv
// Shared types for the reorder/retire buffer: entry layout and the retire word
// that feeds the renamer's retirein port.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned PHYS_W    = 4;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              haswrite;
    logic [PHYS_W-1:0] oldphys;
  } rob_entry_t;

  // Bit 0 is the free request; layout matches the renamer's retirein.
  typedef struct packed {
    logic [PHYS_W-1:0] phys;
    logic              valid;
  } retire_t;

endpackage

// File: rtl/reorder_retire_if.sv
// Dispatch, completion and retire signals between the pipeline and the
// reorder/retire buffer.
interface reorder_retire_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PHYS_W = 4,
    parameter int unsigned TAG_W  = $clog2(DEPTH)
);
    logic              alloc_valid;
    logic              alloc_haswrite;
    logic [PHYS_W-1:0] alloc_oldphys;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              done_valid;
    logic [TAG_W-1:0]  done_tag;
    logic [PHYS_W:0]   retire;
    logic              retire_pulse;
    logic [TAG_W:0]    count;

    modport master (
        output alloc_valid, alloc_haswrite, alloc_oldphys, done_valid, done_tag,
        input  alloc_ready, alloc_tag, retire, retire_pulse, count
    );

    modport slave (
        input  alloc_valid, alloc_haswrite, alloc_oldphys, done_valid, done_tag,
        output alloc_ready, alloc_tag, retire, retire_pulse, count
    );
endinterface

// File: rtl/reorder_retire_ptr.sv
// Circular-buffer pointer: TAG_W index bits plus a wrap bit in the MSB.
module rob_ptr #(
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [TAG_W:0]   ptr
);
    logic [TAG_W:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/reorder_retire.sv
// In-order retirement buffer: records displaced phys regs, retires in program order.
// Optional ROB_DONE_BYPASS_EN lets a same-cycle completion of the head retire immediately.
module reorder_retire #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PHYS_W = 4,
    parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    reorder_retire_if.slave  bus
);
    import rob_pkg::*;

    rob_entry_t       entries_q [DEPTH];
    rob_entry_t       head_entry;
    retire_t          retire_d, retire_q;
    logic             retire_pulse_q;
    logic [TAG_W:0]   head_ptr, tail_ptr;
    logic [TAG_W-1:0] head_idx, tail_idx;
    logic             full, do_alloc, done_hit, head_done, do_retire;

    assign head_idx   = head_ptr[TAG_W-1:0];
    assign tail_idx   = tail_ptr[TAG_W-1:0];
    assign head_entry = entries_q[head_idx];

    assign full            = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
    assign bus.alloc_ready = !full;
    assign bus.alloc_tag   = tail_idx;
    assign bus.count       = tail_ptr - head_ptr;

    assign do_alloc = ena && bus.alloc_valid && !full;
    // Alloc wins over a done aimed at the slot being written this cycle.
    assign done_hit = ena && bus.done_valid && entries_q[bus.done_tag].valid &&
                      !(do_alloc && (bus.done_tag == tail_idx));

`ifdef ROB_DONE_BYPASS_EN
    assign head_done = head_entry.done || (done_hit && (bus.done_tag == head_idx));
`else
    assign head_done = head_entry.done;
`endif

    assign do_retire = ena && head_entry.valid && head_done;

    rob_ptr #(.TAG_W(TAG_W)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (do_retire),
        .ptr (head_ptr)
    );

    rob_ptr #(.TAG_W(TAG_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (do_alloc),
        .ptr (tail_ptr)
    );

    // Head and tail slots coincide only when empty (no retire) or full (no alloc).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            if (done_hit)  entries_q[bus.done_tag].done <= 1'b1;
            if (do_retire) entries_q[head_idx].valid    <= 1'b0;
            if (do_alloc) begin
                entries_q[tail_idx].valid    <= 1'b1;
                entries_q[tail_idx].done     <= 1'b0;
                entries_q[tail_idx].haswrite <= bus.alloc_haswrite;
                entries_q[tail_idx].oldphys  <= bus.alloc_oldphys;
            end
        end
    end

    always_comb begin
        retire_d = '0;
        if (do_retire && head_entry.haswrite) begin
            retire_d.phys  = head_entry.oldphys;
            retire_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q       <= '0;
            retire_pulse_q <= 1'b0;
        end else begin
            retire_q       <= retire_d;
            retire_pulse_q <= do_retire;
        end
    end

    assign bus.retire       = retire_q;
    assign bus.retire_pulse = retire_pulse_q;
endmodule

// File: tb/tb_reorder_retire.sv
// Directed bench for reorder_retire; latency expectations follow ROB_DONE_BYPASS_EN.
module tb_reorder_retire;
    logic clk;
    logic rst;
    logic ena;
    int   tests;
    int   fails;

    reorder_retire_if #(.DEPTH(8), .PHYS_W(4)) bus ();

    reorder_retire #(.DEPTH(8), .PHYS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        ena = 1'b1;
        bus.alloc_valid    = 1'b0;
        bus.alloc_haswrite = 1'b0;
        bus.alloc_oldphys  = '0;
        bus.done_valid     = 1'b0;
        bus.done_tag       = '0;

        // Reset state
        #12;
        check("rst_retire", bus.retire, 0);
        check("rst_pulse", bus.retire_pulse, 0);
        check("rst_count", bus.count, 0);
        check("rst_ready", bus.alloc_ready, 1);
        check("rst_tag", bus.alloc_tag, 0);
        rst = 1'b1;
        step();

        // Three allocs, completed out of order, retire in order
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid    = 1'b1;
            bus.alloc_haswrite = 1'b1;
            bus.alloc_oldphys  = 4'(5 + i);
            check("ooo_tag", bus.alloc_tag, i);
            step();
        end
        bus.alloc_valid = 1'b0;
        check("ooo_count3", bus.count, 3);
        for (int i = 2; i >= 0; i--) begin
            bus.done_valid = 1'b1;
            bus.done_tag   = 3'(i);
            step();
        end
        bus.done_valid = 1'b0;
`ifndef ROB_DONE_BYPASS_EN
        check("ooo_not_yet", bus.retire, 0);
        step();
`endif
        check("ooo_ret5", bus.retire, 5'b01011);
        check("ooo_pulse", bus.retire_pulse, 1);
        step();
        check("ooo_ret6", bus.retire, 5'b01101);
        step();
        check("ooo_ret7", bus.retire, 5'b01111);
        step();
        check("ooo_idle", bus.retire, 0);
        check("ooo_empty", bus.count, 0);

        // Asynchronous reset with entries in flight (slots 3..6)
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid    = 1'b1;
            bus.alloc_haswrite = 1'b1;
            bus.alloc_oldphys  = 4'(1 + i);
            step();
        end
        bus.alloc_valid = 1'b0;
        check("rs_count4", bus.count, 4);
        bus.done_valid = 1'b1;
        bus.done_tag   = 3'd3;
        step();
        bus.done_valid = 1'b0;
`ifndef ROB_DONE_BYPASS_EN
        step();
`endif
        check("rs_count3", bus.count, 3);
        check("rs_ret", bus.retire, 5'b00011);
        #2;
        rst = 1'b0;
        #1;
        check("rs_async_retire", bus.retire, 0);
        check("rs_async_pulse", bus.retire_pulse, 0);
        check("rs_async_count", bus.count, 0);
        check("rs_async_ready", bus.alloc_ready, 1);
        step();
        step();
        rst = 1'b1;
        check("rs_tag0", bus.alloc_tag, 0);
        // Stale pre-reset slot must not be completable or retire
        bus.done_valid = 1'b1;
        bus.done_tag   = 3'd4;
        step();
        bus.done_valid = 1'b0;
        step();
        step();
        check("rs_no_spurious", bus.retire_pulse, 0);
        check("rs_still_empty", bus.count, 0);

        // Fill to full, ignored extra alloc, wrap on reissue
        for (int i = 0; i < 8; i++) begin
            bus.alloc_valid    = 1'b1;
            bus.alloc_haswrite = 1'b1;
            bus.alloc_oldphys  = 4'(8 + i);
            check("fill_tag", bus.alloc_tag, i);
            step();
        end
        check("full_ready", bus.alloc_ready, 0);
        check("full_count", bus.count, 8);
        bus.alloc_oldphys = 4'd1;
        step();
        bus.alloc_valid = 1'b0;
        check("full_ignored", bus.count, 8);
        bus.done_valid = 1'b1;
        bus.done_tag   = 3'd0;
        step();
        bus.done_valid = 1'b0;
`ifndef ROB_DONE_BYPASS_EN
        step();
`endif
        check("full_ret8", bus.retire, 5'b10001);
        check("full_ready_again", bus.alloc_ready, 1);
        check("full_count7", bus.count, 7);
        check("wrap_tag0", bus.alloc_tag, 0);

        // Alloc of a non-writing instr with a same-cycle done to that slot
        bus.alloc_valid    = 1'b1;
        bus.alloc_haswrite = 1'b0;
        bus.alloc_oldphys  = 4'd9;
        bus.done_valid     = 1'b1;
        bus.done_tag       = 3'd0;
        step();
        bus.alloc_valid = 1'b0;
        check("aw_count8", bus.count, 8);
        for (int i = 1; i < 8; i++) begin
            bus.done_tag = 3'(i);
            step();
        end
        bus.done_valid = 1'b0;
        step();
        step();
        step();
        check("aw_left1", bus.count, 1);
        check("aw_quiet", bus.retire_pulse, 0);
        bus.done_valid = 1'b1;
        bus.done_tag   = 3'd0;
        step();
        bus.done_valid = 1'b0;
`ifndef ROB_DONE_BYPASS_EN
        step();
`endif
        check("nowr_retire", bus.retire, 0);
        check("nowr_pulse", bus.retire_pulse, 1);
        check("nowr_count", bus.count, 0);
        step();
        check("nowr_pulse_off", bus.retire_pulse, 0);

        // ena low freezes everything
        check("ena_tag1", bus.alloc_tag, 1);
        bus.alloc_valid    = 1'b1;
        bus.alloc_haswrite = 1'b1;
        bus.alloc_oldphys  = 4'd3;
        step();
        check("ena_count1", bus.count, 1);
        ena               = 1'b0;
        bus.alloc_oldphys = 4'd4;
        bus.done_valid    = 1'b1;
        bus.done_tag      = 3'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ena_hold_count", bus.count, 1);
            check("ena_hold_retire", bus.retire, 0);
            check("ena_hold_pulse", bus.retire_pulse, 0);
        end
        ena             = 1'b1;
        bus.alloc_valid = 1'b0;
        step();
        bus.done_valid = 1'b0;
`ifndef ROB_DONE_BYPASS_EN
        step();
`endif
        check("ena_resume_ret", bus.retire, 5'b00111);
        check("ena_resume_pulse", bus.retire_pulse, 1);
        check("ena_resume_count", bus.count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reorder_retire.md
# reorder_retire

In-order retirement buffer that closes the rename loop. The renamer allocates a new physical register per write and reports the displaced mapping on `oldwrite`. This block records that displaced physical register per dispatched instruction, tracks out-of-order completion, and retires in program order. On each retirement it drives the `{phys, valid}` retire word the renamer consumes to clear its `claimed` bit.

## Interface
Parameters:
- `DEPTH`, 8 — entries; power of two, ≥2.
- `PHYS_W`, 4 — physical register index width (16 physical regs).
- `TAG_W`, $clog2(DEPTH) — entry tag width.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — asynchronous, active-low reset (0 = reset).
- `ena`  in  1  — global advance enable; when 0, no state changes.
- `alloc_valid`  in  1  — dispatch request.
- `alloc_haswrite`  in  1  — instruction wrote a register, so `alloc_oldphys` must be freed at retire.
- `alloc_oldphys`  in  PHYS_W  — displaced physical reg (renamer `oldwrite`).
- `alloc_ready`  out  1  — buffer not full; combinational from count.
- `alloc_tag`  out  TAG_W  — tag assigned to this dispatch (tail index); combinational.
- `done_valid`  in  1  — completion report.
- `done_tag`  in  TAG_W  — tag being completed.
- `retire`  out  PHYS_W+1  — `{phys, valid}`, registered; bit 0 = free request. Connects to renamer `retirein`.
- `retire_pulse`  out  1  — registered; 1 for each retired entry, including non-writing ones.
- `count`  out  TAG_W+1  — occupied entries.

## Operation
- Circular buffer. Per entry: `valid`, `done`, `haswrite`, `oldphys`. `head`/`tail` are TAG_W+1 pointers carrying a wrap bit. Full = indices equal and wrap bits differ. Empty = pointers equal.
- Alloc accepted when `ena && alloc_valid && alloc_ready`:
  - Entry[tail] gets valid=1, done=0, plus `haswrite` and `oldphys`.
  - tail advances.
- Done accepted when `ena && done_valid`:
  - Sets entry[done_tag].done = 1.
  - Ignored if that entry is not valid.
  - Duplicate done is harmless.
- Retire, at most one per cycle, when `ena` and entry[head] is valid and done:
  - Clear entry[head].valid; head advances.
  - Next cycle: `retire` = {entry.oldphys, entry.haswrite}, `retire_pulse` = 1.
  - Otherwise `retire` = 0 and `retire_pulse` = 0 next cycle, including whenever `ena` = 0.
- `retire` bit 0 is 0 when `haswrite` = 0. The phys field is don't-care but is driven 0.
- Simultaneous events:
  - Alloc + retire in the same cycle are both performed; count unchanged.
  - Full: `alloc_ready` = 0 even if a retire occurs that cycle. No same-cycle pass-through.
  - Done to a tag being allocated that same cycle: alloc wins, done = 0.
  - Done to head in the same cycle as the retire check: the check uses registered `done`, so head retires the following cycle. This changes under the Configuration macro.
- Reset mid-operation: all entries invalidated, pointers 0, `retire` 0, `retire_pulse` 0, `count` 0. In-flight entries are discarded, not retired.

## Timing
- Reset values: `retire` = 0, `retire_pulse` = 0, `count` = 0, `alloc_ready` = 1, `alloc_tag` = 0.
- Alloc at edge N: entry visible from N; `count` increments after N.
- Done reported in cycle C: done bit set at edge C. Head retires at edge C+1. `retire` is valid during cycle C+2. Done-to-retire latency is 2 cycles.
- Throughput: 1 alloc + 1 done + 1 retire per cycle.
- Pointer wrap: index DEPTH-1 → 0 and the wrap bit toggles.

## Configuration
- `ROB_DONE_BYPASS_EN` defined:
  - The retire condition also accepts `ena && done_valid && done_tag == head index` with entry[head] valid.
  - Done in cycle C retires at edge C, and `retire` is valid in C+1 (1-cycle latency).
  - The alloc-wins rule still applies: a done that targets the tag being allocated that cycle does not retire.
- Undefined: 2-cycle latency as above. Interface identical in both builds.

## Structure
- Package `rob_pkg`:
  - `ROB_DEPTH` and `PHYS_W` constants.
  - `rob_entry_t` struct {valid, done, haswrite, oldphys}.
  - `retire_t` packed {phys, valid}, bit-compatible with renamer `retirein`.
- Sub-module `rob_ptr`: wrap-bit pointer with increment enable, async active-low reset. Instantiated twice, for head and tail.

## Test plan
- Reset, then alloc 3 entries (oldphys 5, 6, 7; haswrite 1); done tags 2, 1, 0 on consecutive cycles → retires in order 5, 6, 7. `retire` = 5'b01011, 5'b01101, 5'b01111. First retire 2 cycles after done tag 0.
- Fill 8 entries → `alloc_ready` = 0, `count` = 8. A 9th alloc attempt is ignored. Complete head → after retire, `alloc_ready` = 1 and the tag reissued is 0 (wrap).
- Alloc with haswrite = 0, oldphys 9, then done → `retire` = 0 and `retire_pulse` = 1 for one cycle.
- Hold `ena` = 0 for 3 cycles with done_valid and alloc_valid asserted → no count change, `retire` = 0. On `ena` = 1, normal behaviour resumes.
- Assert `rst` = 0 asynchronously mid-stream with 4 entries in flight → outputs 0 immediately. After release, tag 0 is allocated and nothing spurious retires.
- With `ROB_DONE_BYPASS_EN`: done on the head tag → `retire` is valid the next cycle. Without the macro → it is valid 2 cycles later.
